// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage feeding the ID/EX register, 1-cycle latency; EX/MEM forwarding, load-use bubble.
// Backpressure: stall holds the whole bundle, flush kills it, load-use inserts a bubble while fetch holds.
module id_operand_stage #(
   parameter logic [5:0] OPC_LOAD   = 6'h08,
   parameter logic [5:0] OPC_STORE  = 6'h09,
   parameter logic [5:0] OPC_BRANCH = 6'h0C,
   parameter logic [5:0] OPC_RTYPE  = 6'h00
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] if_insn,
   input  logic [31:0] if_pc,
   input  logic        if_en,
   input  logic        stall,
   input  logic        flush,
   output logic [4:0]  gpr_rd_addr_0,
   output logic [4:0]  gpr_rd_addr_1,
   input  logic [31:0] gpr_rd_data_0,
   input  logic [31:0] gpr_rd_data_1,
   input  logic        ex_fwd_en,
   input  logic [4:0]  ex_fwd_addr,
   input  logic [31:0] ex_fwd_data,
   input  logic        mem_fwd_en,
   input  logic [4:0]  mem_fwd_addr,
   input  logic [31:0] mem_fwd_data,
   output logic        ld_hazard,
   output logic        id_en,
   output logic [31:0] id_pc,
   output logic [5:0]  id_opcode,
   output logic [31:0] id_op_a,
   output logic [31:0] id_op_b,
   output logic [31:0] id_imm,
   output logic [4:0]  id_dst_addr,
   output logic        id_dst_we,
   output logic        id_is_load
);

   typedef struct packed {
      logic        en;
      logic [31:0] pc;
      logic [5:0]  opcode;
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [31:0] imm;
      logic [4:0]  dst_addr;
      logic        dst_we;
      logic        is_load;
   } id_bundle_t;

   id_bundle_t id_q;
   id_bundle_t dec;
   logic [5:0] opcode;
   logic [4:0] ra;
   logic [4:0] rb;
   logic       src_hit;

   assign opcode        = if_insn[31:26];
   assign ra            = if_insn[25:21];
   assign rb            = if_insn[20:16];
   assign gpr_rd_addr_0 = ra;
   assign gpr_rd_addr_1 = rb;

   // EX is younger than MEM, so it wins when both hold the same register
   always_comb begin
      dec          = '0;
      dec.en       = if_en;
      dec.pc       = if_pc;
      dec.opcode   = opcode;
      dec.imm      = {{16{if_insn[15]}}, if_insn[15:0]};
      dec.dst_addr = (opcode == OPC_RTYPE) ? if_insn[15:11] : if_insn[20:16];
      dec.dst_we   = !((opcode == OPC_STORE) || (opcode == OPC_BRANCH));
      dec.is_load  = (opcode == OPC_LOAD);

      dec.op_a = gpr_rd_data_0;
      if (ex_fwd_en && ex_fwd_addr == ra)
         dec.op_a = ex_fwd_data;
      else if (mem_fwd_en && mem_fwd_addr == ra)
         dec.op_a = mem_fwd_data;

      dec.op_b = gpr_rd_data_1;
      if (ex_fwd_en && ex_fwd_addr == rb)
         dec.op_b = ex_fwd_data;
      else if (mem_fwd_en && mem_fwd_addr == rb)
         dec.op_b = mem_fwd_data;
   end

   // Both source fields are checked even when the opcode ignores one of them
   assign src_hit   = (id_q.dst_addr == ra) || (id_q.dst_addr == rb);
   assign ld_hazard = if_en && id_q.en && id_q.is_load && id_q.dst_we && src_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         id_q <= '0;
      else if (flush)
         id_q.en <= 1'b0;
      else if (!stall) begin
         if (ld_hazard)
            id_q.en <= 1'b0;
         else
            id_q <= dec;
      end
   end

   assign id_en       = id_q.en;
   assign id_pc       = id_q.pc;
   assign id_opcode   = id_q.opcode;
   assign id_op_a     = id_q.op_a;
   assign id_op_b     = id_q.op_b;
   assign id_imm      = id_q.imm;
   assign id_dst_addr = id_q.dst_addr;
   assign id_dst_we   = id_q.dst_we;
   assign id_is_load  = id_q.is_load;

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: expected bundles queued at drive time, popped after each edge.
module tb_id_operand_stage;

   typedef struct packed {
      logic        en;
      logic [31:0] pc;
      logic [5:0]  opc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  dst;
      logic        we;
      logic        ld;
   } bundle_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] if_insn = '0;
   logic [31:0] if_pc = '0;
   logic        if_en = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1;
   logic [31:0] gpr_rd_data_0, gpr_rd_data_1;
   logic        ex_fwd_en = 1'b0;
   logic [4:0]  ex_fwd_addr = '0;
   logic [31:0] ex_fwd_data = '0;
   logic        mem_fwd_en = 1'b0;
   logic [4:0]  mem_fwd_addr = '0;
   logic [31:0] mem_fwd_data = '0;
   logic        ld_hazard, id_en, id_dst_we, id_is_load;
   logic [31:0] id_pc, id_op_a, id_op_b, id_imm;
   logic [5:0]  id_opcode;
   logic [4:0]  id_dst_addr;

   logic [31:0] gpr [32];
   bundle_t     exp_q [$];
   bundle_t     mdl;
   int          n_chk = 0;
   int          n_fail = 0;

   assign gpr_rd_data_0 = gpr[gpr_rd_addr_0];
   assign gpr_rd_data_1 = gpr[gpr_rd_addr_1];

   always #5 clk = ~clk;

   id_operand_stage dut (
      .clk(clk), .reset(reset), .if_insn(if_insn), .if_pc(if_pc), .if_en(if_en),
      .stall(stall), .flush(flush),
      .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1),
      .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
      .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
      .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
      .ld_hazard(ld_hazard), .id_en(id_en), .id_pc(id_pc), .id_opcode(id_opcode),
      .id_op_a(id_op_a), .id_op_b(id_op_b), .id_imm(id_imm), .id_dst_addr(id_dst_addr),
      .id_dst_we(id_dst_we), .id_is_load(id_is_load)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] opsel(input logic [4:0] r);
      if (ex_fwd_en && ex_fwd_addr == r) return ex_fwd_data;
      if (mem_fwd_en && mem_fwd_addr == r) return mem_fwd_data;
      return gpr[r];
   endfunction

   function automatic bundle_t decode();
      bundle_t d;
      d.en  = if_en;
      d.pc  = if_pc;
      d.opc = if_insn[31:26];
      d.a   = opsel(if_insn[25:21]);
      d.b   = opsel(if_insn[20:16]);
      d.imm = {{16{if_insn[15]}}, if_insn[15:0]};
      d.dst = (d.opc == 6'h00) ? if_insn[15:11] : if_insn[20:16];
      d.we  = !(d.opc == 6'h09 || d.opc == 6'h0C);
      d.ld  = (d.opc == 6'h08);
      return d;
   endfunction

   task automatic check_outputs(input string tag, input bundle_t e);
      chk({tag, ".en"},  {31'd0, id_en}, {31'd0, e.en});
      chk({tag, ".pc"},  id_pc, e.pc);
      chk({tag, ".opc"}, {26'd0, id_opcode}, {26'd0, e.opc});
      chk({tag, ".a"},   id_op_a, e.a);
      chk({tag, ".b"},   id_op_b, e.b);
      chk({tag, ".imm"}, id_imm, e.imm);
      chk({tag, ".dst"}, {27'd0, id_dst_addr}, {27'd0, e.dst});
      chk({tag, ".we"},  {31'd0, id_dst_we}, {31'd0, e.we});
      chk({tag, ".ld"},  {31'd0, id_is_load}, {31'd0, e.ld});
   endtask

   // Drive one cycle of stimulus, predict the hazard and next bundle, then compare after the edge.
   task automatic step(input string tag, input logic [31:0] insn, input logic [31:0] pc,
                       input logic en, input logic st, input logic fl);
      bundle_t nxt;
      logic    hz;
      if_insn = insn; if_pc = pc; if_en = en; stall = st; flush = fl;
      #1;
      hz = en && mdl.en && mdl.ld && mdl.we &&
           (mdl.dst == insn[25:21] || mdl.dst == insn[20:16]);
      chk({tag, ".hazard"}, {31'd0, ld_hazard}, {31'd0, hz});
      nxt = mdl;
      if (fl) nxt.en = 1'b0;
      else if (st) nxt = mdl;
      else if (hz) nxt.en = 1'b0;
      else nxt = decode();
      exp_q.push_back(nxt);
      mdl = nxt;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) chk({tag, ".queue"}, 32'd0, 32'd1);
      else check_outputs(tag, exp_q.pop_front());
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 11'h0};
   endfunction

   initial begin
      logic [31:0] ri;
      logic [5:0]  opcs [5];
      opcs[0] = 6'h00; opcs[1] = 6'h08; opcs[2] = 6'h09; opcs[3] = 6'h0C; opcs[4] = 6'h21;
      for (int i = 0; i < 32; i++) gpr[i] = 32'h1000 + i * 32'h11;
      gpr[3] = 32'd5;
      gpr[4] = 32'd7;
      mdl = '0;

      // Reset held with a valid instruction present
      if_en = 1'b1; if_insn = rtype(5'd3, 5'd4, 5'd9); if_pc = 32'h100;
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset", '0);
      reset = 1'b0;

      step("first", rtype(5'd3, 5'd4, 5'd9), 32'h100, 1'b1, 1'b0, 1'b0);
      chk("rtype.op_a", id_op_a, 32'd5);
      chk("rtype.op_b", id_op_b, 32'd7);
      chk("rtype.dst", {27'd0, id_dst_addr}, 32'd9);
      chk("rtype.we", {31'd0, id_dst_we}, 32'd1);
      chk("rtype.en", {31'd0, id_en}, 32'd1);

      ex_fwd_en = 1'b1; ex_fwd_addr = 5'd3; ex_fwd_data = 32'hAA;
      mem_fwd_en = 1'b1; mem_fwd_addr = 5'd3; mem_fwd_data = 32'hBB;
      step("fwd_both", rtype(5'd3, 5'd4, 5'd10), 32'h104, 1'b1, 1'b0, 1'b0);
      chk("fwd_ex_prio", id_op_a, 32'hAA);
      ex_fwd_en = 1'b0;
      step("fwd_mem", rtype(5'd3, 5'd4, 5'd10), 32'h108, 1'b1, 1'b0, 1'b0);
      chk("fwd_mem_only", id_op_a, 32'hBB);

      // r0 forwards like any other register
      ex_fwd_en = 1'b1; ex_fwd_addr = 5'd0; ex_fwd_data = 32'hC0DE;
      mem_fwd_addr = 5'd4; mem_fwd_data = 32'hD00D;
      step("fwd_r0", rtype(5'd0, 5'd4, 5'd1), 32'h10C, 1'b1, 1'b0, 1'b0);
      chk("fwd_r0.a", id_op_a, 32'hC0DE);
      chk("fwd_mem.b", id_op_b, 32'hD00D);
      ex_fwd_en = 1'b0; mem_fwd_en = 1'b0;

      step("load", {6'h08, 5'd1, 5'd5, 16'h0010}, 32'h200, 1'b1, 1'b0, 1'b0);
      step("use1", rtype(5'd5, 5'd6, 5'd7), 32'h204, 1'b1, 1'b0, 1'b0);
      chk("use1.bubble", {31'd0, id_en}, 32'd0);
      step("use2", rtype(5'd5, 5'd6, 5'd7), 32'h204, 1'b1, 1'b0, 1'b0);
      chk("use2.en", {31'd0, id_en}, 32'd1);
      chk("use2.pc", id_pc, 32'h204);

      // Hazard pending while stalled: hold wins, then the bubble follows
      step("load2", {6'h08, 5'd1, 5'd5, 16'h0010}, 32'h208, 1'b1, 1'b0, 1'b0);
      step("hz_stall", rtype(5'd6, 5'd5, 5'd7), 32'h20C, 1'b1, 1'b1, 1'b0);
      chk("hz_stall.en", {31'd0, id_en}, 32'd1);
      step("hz_bubble", rtype(5'd6, 5'd5, 5'd7), 32'h20C, 1'b1, 1'b0, 1'b0);
      step("hz_go", rtype(5'd6, 5'd5, 5'd7), 32'h20C, 1'b1, 1'b0, 1'b0);

      step("pre_fl", rtype(5'd3, 5'd4, 5'd2), 32'h300, 1'b1, 1'b0, 1'b0);
      step("flush_stall", rtype(5'd3, 5'd4, 5'd2), 32'h304, 1'b1, 1'b1, 1'b1);
      chk("flush_stall.en", {31'd0, id_en}, 32'd0);
      step("pre_st", rtype(5'd3, 5'd4, 5'd2), 32'h308, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         step("stall", rtype(5'd8, 5'd9, 5'd11), 32'h400 + i, 1'b1, 1'b1, 1'b0);
      chk("stall.pc", id_pc, 32'h308);
      chk("stall.en", {31'd0, id_en}, 32'd1);

      step("store", {6'h09, 5'd2, 5'd3, 16'h8000}, 32'h500, 1'b1, 1'b0, 1'b0);
      chk("store.imm", id_imm, 32'hFFFF8000);
      chk("store.we", {31'd0, id_dst_we}, 32'd0);
      chk("store.ld", {31'd0, id_is_load}, 32'd0);
      step("idle", rtype(5'd1, 5'd2, 5'd3), 32'h504, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         ri = $urandom;
         ri[31:26] = opcs[$urandom_range(0, 4)];
         ri[25:21] = 5'($urandom_range(0, 7));
         ri[20:16] = 5'($urandom_range(0, 7));
         ri[15:11] = 5'($urandom_range(0, 7));
         ex_fwd_en = 1'($urandom_range(0, 1)); ex_fwd_addr = 5'($urandom_range(0, 7));
         ex_fwd_data = $urandom;
         mem_fwd_en = 1'($urandom_range(0, 1)); mem_fwd_addr = 5'($urandom_range(0, 7));
         mem_fwd_data = $urandom;
         step("rand", ri, $urandom, ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      end

      // Asynchronous reset between edges clears the bundle at once
      step("pre_rst", rtype(5'd3, 5'd4, 5'd9), 32'h600, 1'b1, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      check_outputs("async_rst", '0);
      @(negedge clk);
      reset = 1'b0;
      mdl = '0;
      ex_fwd_en = 1'b0; mem_fwd_en = 1'b0;
      step("post_rst", rtype(5'd3, 5'd4, 5'd9), 32'h604, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
